// File: rtl/if_window_scheduler_pkg.sv
// Shared definitions for the IF window scheduler: FSM state encoding and
// default geometry of the IF scratchpad.
package if_sched_pkg;

  localparam int ADDR_LEN_DEF      = 4;
  localparam int SCRATCH_DEPTH_DEF = 16;
  localparam int FILT_W_DEF        = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    INIT = ST_INIT,
    READ = ST_READ,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/if_window_scheduler_if.sv
// Bus between the window scheduler, the IF buffer-read block (row pointers)
// and the PE (read handshake).
interface if_window_scheduler_if #(
  parameter int ADDR_LEN = if_sched_pkg::ADDR_LEN_DEF,
  parameter int FILT_W   = if_sched_pkg::FILT_W_DEF
);

  logic                start;
  logic [FILT_W-1:0]   filt_len;
  logic [FILT_W-1:0]   stride;
  logic                IF_end_valid;
  logic [ADDR_LEN-1:0] start_IF;
  logic [ADDR_LEN-1:0] end_IF;
  logic [ADDR_LEN-1:0] IF_waddr;
  logic                pe_ready;
  logic [ADDR_LEN-1:0] IF_raddr;
  logic                IF_ren;
  logic                win_first;
  logic                win_last;
  logic                full_done;
  logic                busy;

  modport master (
    input  start, filt_len, stride, IF_end_valid, start_IF, end_IF, IF_waddr, pe_ready,
    output IF_raddr, IF_ren, win_first, win_last, full_done, busy
  );

  modport slave (
    output start, filt_len, stride, IF_end_valid, start_IF, end_IF, IF_waddr, pe_ready,
    input  IF_raddr, IF_ren, win_first, win_last, full_done, busy
  );

endinterface

// File: rtl/if_window_scheduler_circ_dist.sv
// Circular distance d(a,b) = (b - a + DEPTH) mod DEPTH on the scratchpad ring.
module circ_dist
  import if_sched_pkg::*;
#(
  parameter int ADDR_LEN      = ADDR_LEN_DEF,
  parameter int SCRATCH_DEPTH = SCRATCH_DEPTH_DEF
) (
  input  logic [ADDR_LEN-1:0] a,
  input  logic [ADDR_LEN-1:0] b,
  output logic [ADDR_LEN:0]   d
);

  localparam logic [ADDR_LEN:0] DEPTH = (ADDR_LEN+1)'(SCRATCH_DEPTH);

  logic [ADDR_LEN:0] raw;

  // Bias by DEPTH first so the subtraction never goes negative.
  assign raw = {1'b0, b} + DEPTH - {1'b0, a};
  assign d   = (raw >= DEPTH) ? raw - DEPTH : raw;

endmodule

// File: rtl/if_window_scheduler.sv
// Sweeps an L-long window with stride S over the IF row held in the circular
// scratchpad, one read per cycle under pe_ready, and pulses full_done at row end.
module if_window_scheduler
  import if_sched_pkg::*;
#(
  parameter int ADDR_LEN      = ADDR_LEN_DEF,
  parameter int SCRATCH_DEPTH = SCRATCH_DEPTH_DEF,
  parameter int FILT_W        = FILT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  if_window_scheduler_if.master bus
);

  localparam int OW = ADDR_LEN + 2;

  state_e              state, state_nxt;
  logic [ADDR_LEN:0]   wb, wb_nxt;
  logic [FILT_W-1:0]   k, k_nxt;
  logic [FILT_W-1:0]   l_len, l_nxt;
  logic [FILT_W-1:0]   s_len, s_nxt;

  logic [ADDR_LEN:0]   dist_end, dist_wr;
  logic [OW-1:0]       offs, row_len, win_end;
  logic                avail, exhausted, ren, accept, last_k;

  function automatic logic [FILT_W-1:0] at_least_one(input logic [FILT_W-1:0] v);
    return (v == '0) ? FILT_W'(1) : v;
  endfunction

  function automatic logic [ADDR_LEN-1:0] wrap_addr(input logic [ADDR_LEN-1:0] base,
                                                    input logic [OW-1:0]       off);
    logic [OW:0] sum;
    sum = (OW+1)'(base) + (OW+1)'(off);
    return ADDR_LEN'(sum % (OW+1)'(SCRATCH_DEPTH));
  endfunction

  circ_dist #(.ADDR_LEN(ADDR_LEN), .SCRATCH_DEPTH(SCRATCH_DEPTH)) u_dist_end (
    .a(bus.start_IF), .b(bus.end_IF), .d(dist_end)
  );

  circ_dist #(.ADDR_LEN(ADDR_LEN), .SCRATCH_DEPTH(SCRATCH_DEPTH)) u_dist_wr (
    .a(bus.start_IF), .b(bus.IF_waddr), .d(dist_wr)
  );

  assign offs    = OW'(wb) + OW'(k);
  assign row_len = OW'(dist_end) + OW'(1);
  assign win_end = OW'(wb) + OW'(l_len);

  // A closed row bounds reads by its last element; an open row by the writer.
  assign avail     = bus.IF_end_valid ? (offs <= OW'(dist_end)) : (offs < OW'(dist_wr));
  assign exhausted = (state == READ) && (k == '0) && bus.IF_end_valid && (win_end > row_len);
  assign ren       = (state == READ) && avail && !exhausted;
  assign last_k    = (k == l_len - FILT_W'(1));
  assign accept    = ren && bus.pe_ready;

  assign bus.IF_ren    = ren;
  assign bus.IF_raddr  = (state == READ) ? wrap_addr(bus.start_IF, offs) : '0;
  assign bus.win_first = ren && (k == '0);
  assign bus.win_last  = ren && last_k;
  assign bus.full_done = (state == DONE) && !bus.start;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wb    <= '0;
      k     <= '0;
      l_len <= FILT_W'(1);
      s_len <= FILT_W'(1);
    end else begin
      state <= state_nxt;
      wb    <= wb_nxt;
      k     <= k_nxt;
      l_len <= l_nxt;
      s_len <= s_nxt;
    end
  end

  // start overrides everything, including a same-cycle accept.
  always_comb begin
    state_nxt = state;
    wb_nxt    = wb;
    k_nxt     = k;
    l_nxt     = l_len;
    s_nxt     = s_len;
    if (bus.start) begin
      state_nxt = INIT;
      l_nxt     = at_least_one(bus.filt_len);
      s_nxt     = at_least_one(bus.stride);
    end else begin
      case (state)
        IDLE: ;
        INIT: begin
          wb_nxt    = '0;
          k_nxt     = '0;
          state_nxt = READ;
        end
        READ: begin
          if (exhausted) begin
            state_nxt = DONE;
          end else if (accept) begin
            if (last_k) begin
              k_nxt  = '0;
              wb_nxt = wb + (ADDR_LEN+1)'(s_len);
            end else begin
              k_nxt  = k + FILT_W'(1);
            end
          end
        end
        DONE: begin
          wb_nxt    = '0;
          k_nxt     = '0;
          state_nxt = READ;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_window_scheduler.sv
// Directed bench for if_window_scheduler: row sweeps, wrap, writer stall,
// short row, backpressure, restart and asynchronous reset.
module tb_if_window_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_window_scheduler_if #(.ADDR_LEN(4), .FILT_W(4)) bus();

  if_window_scheduler #(.ADDR_LEN(4), .SCRATCH_DEPTH(16), .FILT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic ev, input logic [3:0] s, input logic [3:0] e,
                         input logic [3:0] w);
    bus.IF_end_valid = ev;
    bus.start_IF     = s;
    bus.end_IF       = e;
    bus.IF_waddr     = w;
  endtask

  // Pulse start, check INIT, and return positioned in the first READ cycle.
  task automatic kick(input logic [3:0] l, input logic [3:0] s);
    bus.start    = 1'b1;
    bus.filt_len = l;
    bus.stride   = s;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("init_busy", bus.busy, 1);
    chk("init_ren", bus.IF_ren, 0);
    cyc();
  endtask

  // Follow a row to completion, acting as the writer when full_done pulses.
  task automatic sweep(input string tag, input int l, input int done_at);
    int idx      = 0;
    int dones    = 0;
    int done_cyc = -1;
    for (int c = 0; c < done_at + 4; c++) begin
      @(negedge clk);
      if (bus.IF_ren) begin
        if (idx < exp_addr.size()) begin
          chk({tag, "_addr"}, bus.IF_raddr, exp_addr[idx]);
          chk({tag, "_first"}, bus.win_first, (idx % l) == 0);
          chk({tag, "_last"}, bus.win_last, (idx % l) == l - 1);
        end
        idx++;
      end
      if (bus.full_done) begin
        dones++;
        done_cyc = c;
      end
      cyc();
      if (done_cyc == c) begin
        bus.start_IF     = bus.end_IF + 4'd1;
        bus.IF_waddr     = bus.start_IF;
        bus.IF_end_valid = 1'b0;
      end
    end
    chk({tag, "_nreads"}, idx, exp_addr.size());
    chk({tag, "_ndone"}, dones, 1);
    chk({tag, "_done_cyc"}, done_cyc, done_at);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.filt_len = 4'd0;
    bus.stride   = 4'd0;
    bus.pe_ready = 1'b1;
    set_row(1'b1, 4'd5, 4'd9, 4'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_raddr", bus.IF_raddr, 0);
    chk("rst_ren", bus.IF_ren, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.full_done, 0);
    cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    cyc();

    // Basic sweep L=3 S=1 over 0..4
    set_row(1'b1, 4'd0, 4'd4, 4'd0);
    kick(4'd3, 4'd1);
    exp_addr = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    sweep("basic", 3, 10);

    // Stride 2 with wrap, row 14..4
    set_row(1'b1, 4'd14, 4'd4, 4'd0);
    kick(4'd3, 4'd2);
    exp_addr = '{14, 15, 0, 0, 1, 2, 2, 3, 4};
    sweep("wrap", 3, 10);

    // Open row: writer at 2, then advances to 3
    set_row(1'b0, 4'd0, 4'd0, 4'd2);
    kick(4'd3, 4'd1);
    @(negedge clk);
    chk("stall_a0", bus.IF_raddr, 0);
    chk("stall_ren0", bus.IF_ren, 1);
    chk("stall_first", bus.win_first, 1);
    cyc();
    @(negedge clk);
    chk("stall_a1", bus.IF_raddr, 1);
    chk("stall_ren1", bus.IF_ren, 1);
    cyc();
    @(negedge clk);
    chk("stall_ren2", bus.IF_ren, 0);
    chk("stall_a2", bus.IF_raddr, 2);
    bus.IF_waddr = 4'd3;
    #1;
    chk("stall_release", bus.IF_ren, 1);
    chk("stall_last", bus.win_last, 1);
    cyc();

    // Short row N=2 < L=3
    set_row(1'b1, 4'd5, 4'd6, 4'd0);
    kick(4'd3, 4'd1);
    exp_addr.delete();
    sweep("short", 3, 1);

    // start coincident with DONE suppresses full_done
    set_row(1'b1, 4'd5, 4'd6, 4'd0);
    kick(4'd3, 4'd1);
    @(negedge clk);
    chk("sup_ren", bus.IF_ren, 0);
    cyc();
    bus.start = 1'b1;
    @(negedge clk);
    chk("sup_done", bus.full_done, 0);
    chk("sup_busy", bus.busy, 1);
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("sup_init_ren", bus.IF_ren, 0);
    cyc();

    // Backpressure at raddr 1, then restart mid-row
    set_row(1'b1, 4'd0, 4'd4, 4'd0);
    bus.pe_ready = 1'b1;
    kick(4'd3, 4'd1);
    @(negedge clk);
    chk("bp_a0", bus.IF_raddr, 0);
    cyc();
    bus.pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ren", bus.IF_ren, 1);
      chk("bp_addr", bus.IF_raddr, 1);
      chk("bp_first", bus.win_first, 0);
      cyc();
    end
    bus.pe_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", bus.IF_raddr, 1);
    cyc();
    @(negedge clk);
    chk("bp_next", bus.IF_raddr, 2);
    bus.start    = 1'b1;
    bus.filt_len = 4'd3;
    bus.stride   = 4'd1;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("rs_busy", bus.busy, 1);
    chk("rs_ren", bus.IF_ren, 0);
    chk("rs_done", bus.full_done, 0);
    cyc();
    exp_addr = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    sweep("restart", 3, 10);

    // Asynchronous reset mid-READ
    set_row(1'b1, 4'd0, 4'd4, 4'd0);
    kick(4'd3, 4'd1);
    @(negedge clk);
    chk("ar_pre_ren", bus.IF_ren, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("ar_ren", bus.IF_ren, 0);
    chk("ar_raddr", bus.IF_raddr, 0);
    chk("ar_first", bus.win_first, 0);
    chk("ar_last", bus.win_last, 0);
    chk("ar_done", bus.full_done, 0);
    chk("ar_busy", bus.busy, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_post_ren", bus.IF_ren, 0);
      chk("ar_post_busy", bus.busy, 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_window_scheduler.md
# if_window_scheduler

Sequences reads from the circular input-feature (IF) scratchpad for the PE.
- Sweeps a filter window of length L with stride S across the row currently held between `start_IF` and `end_IF`, issuing one read address per cycle under a ready handshake.
- Pulses `full_done` when the row is exhausted, so the IF buffer-read block frees the row and advances its start pointer.
- Sits between the IF buffer-read block (writer side) and the PE (consumer side) and closes the loop on `full_done`.

## Interface
- `ADDR_LEN`, 4: scratchpad address width.
- `SCRATCH_DEPTH`, 16: scratchpad entries; all pointer arithmetic is modulo this.
- `FILT_W`, 4: width of `filt_len` and `stride`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: restart pulse; has priority in every state.
- `filt_len` in `FILT_W`: filter length L, sampled when `start` is high; 0 is treated as 1.
- `stride` in `FILT_W`: window stride S, sampled when `start` is high; 0 is treated as 1.
- `IF_end_valid` in 1: `end_IF` marks the last element of the current row.
- `start_IF` in `ADDR_LEN`: first element of the current row.
- `end_IF` in `ADDR_LEN`: last element of the row; meaningful only when `IF_end_valid` is high.
- `IF_waddr` in `ADDR_LEN`: writer pointer, the next entry to be written.
- `pe_ready` in 1: PE accepts the current read this cycle.
- `IF_raddr` out `ADDR_LEN`: scratchpad read address.
- `IF_ren` out 1: read request; the current element is available.
- `win_first` out 1: `IF_ren` is for element k=0 of a window.
- `win_last` out 1: `IF_ren` is for element k=L-1 of a window.
- `full_done` out 1: one-cycle pulse; the row is consumed.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, INIT, READ, DONE.
- Transitions:
  - Reset → IDLE.
  - `start` → INIT from any state.
  - INIT → READ.
  - READ → DONE when the row is exhausted.
  - DONE → READ.
  - IDLE is left only on `start`.
- Registers:
  - Window base `wb`, `ADDR_LEN+1` bits.
  - Element index `k`, `FILT_W` bits.
  - Latched L and S.
  - INIT clears `wb` and `k`.
- Circular distance: d(a,b) = (b − a + SCRATCH_DEPTH) mod SCRATCH_DEPTH, computed in `ADDR_LEN+1` bits.
- Offset: o = wb + k.
- Read address: `IF_raddr` = (`start_IF` + o) mod SCRATCH_DEPTH.
- Availability (READ state):
  - With `IF_end_valid`=1: o ≤ d(`start_IF`,`end_IF`).
  - With `IF_end_valid`=0: o < d(`start_IF`,`IF_waddr`).
- Row length N = d(`start_IF`,`end_IF`) + 1.
- Exhaustion:
  - Condition: in READ with k=0, `IF_end_valid`=1 and wb + L > N.
  - Compare in `ADDR_LEN+2` bits.
  - This also covers N < L: zero windows are issued.
- Within READ:
  - `IF_ren` = available & not exhausted.
  - Unavailable element → stall, `IF_ren`=0, all registers hold.
  - Accept = `IF_ren` & `pe_ready`.
  - On accept with k<L-1: k++.
  - On accept with k=L-1: k←0, wb←wb+S.
- DONE:
  - Clears `wb` and `k`.
  - `full_done` = (state==DONE) & ~`start`.

## Timing
- Reset values:
  - State IDLE.
  - `IF_raddr`=0; `IF_ren`, `win_first`, `win_last`, `full_done` and `busy` are 0.
  - `wb`=0, `k`=0, latched L=S=1.
- State and counters are registered; `IF_ren`, `IF_raddr`, `win_first`, `win_last` are combinational from state, registers and inputs.
- Latency and throughput:
  - `start` → first possible `IF_ren`: 2 cycles (INIT, then READ).
  - Peak rate is one accepted read per cycle.
- While `pe_ready`=0, `IF_raddr`, `IF_ren`, `win_first` and `win_last` stay stable.
- Scratchpad read data returns one cycle after accept; the PE aligns to it.
- `full_done` behaviour:
  - High for exactly one cycle.
  - The writer loads `start_IF` ← `end_IF`+1 and drops `IF_end_valid` on that edge.
  - The next READ therefore sees the new row.
- Wrap-around: `IF_raddr` wraps from SCRATCH_DEPTH−1 to 0 with no bubble.
- Simultaneous events:
  - `start` coincident with DONE suppresses `full_done`.
  - `start` coincident with an accept discards the accept's register updates.
- `rst` mid-row forces IDLE immediately and clears all outputs asynchronously.
- `IF_end_valid` may rise mid-window; availability switches to the `end_IF` rule in the same cycle.

## Structure
- Shared package `if_sched_pkg` holds:
  - State encoding localparams (IDLE=0, INIT=1, READ=2, DONE=3).
  - Defaults for `ADDR_LEN`, `SCRATCH_DEPTH`, `FILT_W`.
- One combinational sub-module, `circ_dist`: computes d(a,b) for parameterised depth.
  - Instantiated twice, for (`start_IF`,`end_IF`) and (`start_IF`,`IF_waddr`).
- The k and wb counters are inline.

## Test plan
All scenarios use DEPTH=16, with `pe_ready`=1 unless stated otherwise.
1. Reset check: assert `rst` mid-READ → all outputs 0 the same cycle; `busy`=0; no `IF_ren` until the next `start`.
2. Basic sweep: L=3, S=1, `start_IF`=0, `end_IF`=4, `IF_end_valid`=1 → `IF_raddr` sequence 0,1,2,1,2,3,2,3,4 (9 `IF_ren` cycles, `win_first` on 0,1,2, `win_last` on 2,3,4), then a single `full_done` pulse.
3. Stride and wrap: L=3, S=2, `start_IF`=14, `end_IF`=4 (N=7) → 14,15,0,0,1,2,2,3,4, then `full_done`.
4. Writer stall: `IF_end_valid`=0, `start_IF`=0, `IF_waddr`=2, L=3 → `IF_ren`=0 at `IF_raddr`=2 while 0,1 are accepted; `IF_waddr`→3 gives `IF_ren`=1 in the same cycle.
5. Short row: L=3, N=2 (`start_IF`=5, `end_IF`=6) → no `IF_ren`; `full_done` pulses in the cycle after the first READ.
6. Backpressure and restart:
   - `pe_ready`=0 for 3 cycles at `IF_raddr`=1 → address and `IF_ren` hold.
   - `start` mid-row → INIT, then READ from wb=0; `full_done` suppressed.
